// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the single-port SRAM behavioural models.
// Provides the init-sequencer state encoding, a constant clog2 and an elaboration-time parameter check.
`ifndef SRAM_MODEL_PKG_SV
`define SRAM_MODEL_PKG_SV

package sram_model_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// Stops elaboration when the address width does not match the depth.
`define SRAM_MODEL_PARAM_CHECK(AW, DEPTH) \
    if ((AW) != sram_model_pkg::clog2(DEPTH)) begin : g_param_err \
        $error("Add_Width must equal clog2(Word_Depth)"); \
    end

`endif

// File: rtl/sram_init_seq.sv
// Post-reset clear sequencer: INIT for one cycle, CLEAR for Word_Depth cycles, then READY until reset.
// Latency: init_done rises Word_Depth+1 cycles after reset release; no backpressure, free-running sweep.
module sram_init_seq
    import sram_model_pkg::*;
#(
    parameter int Word_Depth = 128,
    parameter int Add_Width  = 7
) (
    input  logic                 clk,
    input  logic                 rstb,
    output logic                 clr_we,
    output logic [Add_Width-1:0] clr_addr,
    output logic                 init_done
);

    localparam logic [Add_Width-1:0] LastAddr = Add_Width'(Word_Depth - 1);

    state_t               state;
    state_t               state_nxt;
    logic [Add_Width-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_CLEAR) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt == LastAddr) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        clr_we    = (state == ST_CLEAR);
        clr_addr  = cnt;
        init_done = (state == ST_READY);
    end

endmodule

// File: rtl/sram_1p_mask_init.sv
// Single-port SRAM model with per-bit write mask, Q hold and post-reset clear; SRAM_RANDOMIZE_EN randomises Q/sweep.
// Latency: read data on Q one cycle after the read; no backpressure, accesses ignored until INIT_DONE.
module sram_1p_mask_init
    import sram_model_pkg::*;
#(
    parameter int              Bits       = 3,
    parameter int              Word_Depth = 128,
    parameter int              Add_Width  = 7,
    parameter logic [Bits-1:0] Init_Value = '0
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [Bits-1:0]      BWEB,
    input  logic [Add_Width-1:0] A,
    input  logic [Bits-1:0]      D,
    output logic [Bits-1:0]      Q,
    output logic                 INIT_DONE
);

    `SRAM_MODEL_PARAM_CHECK(Add_Width, Word_Depth)

    logic [Bits-1:0]      ram [Word_Depth];
    logic                 clr_we;
    logic [Add_Width-1:0] clr_addr;
    logic                 init_done;
    logic                 addr_ok;
    logic                 user_we;
    logic                 user_re;
    logic                 wr_en;
    logic [Add_Width-1:0] wr_addr;
    logic [Bits-1:0]      merged;

    sram_init_seq #(
        .Word_Depth (Word_Depth),
        .Add_Width  (Add_Width)
    ) u_init_seq (
        .clk       (CLK),
        .rstb      (RSTB),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign INIT_DONE = init_done;

    // Out-of-range addresses only exist for non power-of-two depths.
    assign addr_ok = ({1'b0, A} < (Add_Width + 1)'(Word_Depth));
    assign user_we = RSTB && init_done && !CEB && !WEB && addr_ok;
    assign user_re = RSTB && init_done && !CEB && WEB;
    assign wr_en   = (RSTB && clr_we) || user_we;
    assign wr_addr = clr_we ? clr_addr : A;
    assign merged  = (ram[wr_addr] & BWEB) | (D & ~BWEB);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
`ifdef SRAM_RANDOMIZE_EN
            ram[wr_addr] <= clr_we ? Bits'($random) : merged;
`else
            ram[wr_addr] <= clr_we ? Init_Value : merged;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
`ifdef SRAM_RANDOMIZE_EN
            Q <= Bits'($random);
`else
            Q <= '0;
`endif
        end else if (user_re) begin
            Q <= addr_ok ? ram[A] : '0;
        end else begin
`ifdef SRAM_RANDOMIZE_EN
            Q <= Bits'($random);
`else
            Q <= Q;
`endif
        end
    end

endmodule

// File: tb/tb_sram_1p_mask_init.sv
// Randomised bench for sram_1p_mask_init against an array-based reference model.
module tb_sram_1p_mask_init;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ceb;
    logic       web;
    logic [2:0] bweb;
    logic [6:0] a;
    logic [2:0] d;
    logic [2:0] q;
    logic       init_done;

    bit   [2:0] mem [128];
    bit   [2:0] q_exp;
    int         n_checks = 0;
    int         n_pass   = 0;

    sram_1p_mask_init #(
        .Bits       (3),
        .Word_Depth (128),
        .Add_Width  (7),
        .Init_Value (3'b000)
    ) dut (
        .CLK       (clk),
        .RSTB      (rstb),
        .CEB       (ceb),
        .WEB       (web),
        .BWEB      (bweb),
        .A         (a),
        .D         (d),
        .Q         (q),
        .INIT_DONE (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ceb  = 1'b1;
        web  = 1'b1;
        bweb = 3'b111;
        a    = '0;
        d    = '0;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [2:0] data, input logic [2:0] mask);
        ceb = 1'b0; web = 1'b0; a = addr; d = data; bweb = mask;
        tick();
        for (int b = 0; b < 3; b++)
            if (!mask[b]) mem[addr][b] = data[b];
        check("write_q_hold", q, q_exp);
        set_idle();
    endtask

    task automatic do_read(input string tag, input logic [6:0] addr);
        ceb = 1'b0; web = 1'b1; a = addr; bweb = 3'($urandom); d = 3'($urandom);
        tick();
        q_exp = mem[addr];
        check(tag, q, q_exp);
        set_idle();
    endtask

    task automatic do_idle(input string tag);
        set_idle();
        a = 7'($urandom);
        tick();
        check(tag, q, q_exp);
    endtask

    task automatic apply_reset(input int cycles);
        rstb = 1'b0;
        repeat (cycles) tick();
        q_exp = '0;
        check("reset_q", q, 32'(q_exp));
        check("reset_init_done", init_done, 0);
    endtask

    // Sweep is one INIT cycle plus one write per word; contents become Init_Value.
    task automatic release_and_sweep();
        rstb = 1'b1;
        for (int i = 1; i <= 129; i++) begin
            tick();
            check("sweep_init_done", init_done, (i == 129) ? 1 : 0);
            if (i == 64) check("sweep_q_zero", q, 0);
        end
        for (int k = 0; k < 128; k++) mem[k] = 3'b000;
        set_idle();
    endtask

    initial begin
        set_idle();
        apply_reset(3);

        // Accesses during the sweep must be ignored.
        ceb = 1'b0; web = 1'b0; a = 7'd9; d = 3'b110; bweb = 3'b000;
        release_and_sweep();
        do_read("ignored_write_a9", 7'd9);
        do_read("clear_a0", 7'd0);
        do_read("clear_a127", 7'd127);

        do_write(7'd5, 3'b111, 3'b010);
        do_read("masked_a5", 7'd5);
        check("masked_a5_value", q, 3'b101);
        repeat (4) do_idle("hold_idle");
        do_write(7'd6, 3'b011, 3'b000);
        check("hold_after_write", q, 3'b101);
        do_read("write_a6", 7'd6);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0:       do_idle("rand_idle");
                1:       do_write(7'($urandom), 3'($urandom), 3'($urandom));
                default: do_read("rand_read", 7'($urandom));
            endcase
            if (n % 100 == 0) check("rand_init_done", init_done, 1);
        end

        // Fill with ones, then reset partway through a fresh sweep.
        for (int k = 0; k < 128; k++) do_write(7'(k), 3'b111, 3'b000);
        do_read("filled_a127", 7'd127);
        apply_reset(1);
        rstb = 1'b1;
        repeat (61) tick();
        check("midsweep_not_done", init_done, 0);
        apply_reset(2);
        release_and_sweep();
        do_read("resweep_a0", 7'd0);
        do_read("resweep_a127", 7'd127);
        do_read("resweep_a60", 7'd60);
        do_read("resweep_a100", 7'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
